// File: rtl/seg_pattern_sequencer.sv
// Clocked seven-segment pattern sequencer: hold/forward/reverse/ping-pong stepping with
// programmable dwell. Optional output blanking is compiled in with `define SEQ_BLANK_EN.
module seg_pattern_sequencer #(
  parameter int unsigned SEG_W   = 7,
  parameter int unsigned NUM_PAT = 16,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_PAT*SEG_W-1:0] i_patterns,
  input  logic                     i_en,
  input  logic [1:0]               i_mode,
  input  logic [DWELL_W-1:0]       i_dwell,
  input  logic [SEL_W-1:0]         i_last,
  input  logic                     i_load,
  input  logic [SEL_W-1:0]         i_load_idx,
`ifdef SEQ_BLANK_EN
  input  logic                     i_blank,
`endif
  output logic [SEG_W-1:0]         o_seg,
  output logic [SEL_W-1:0]         o_idx,
  output logic                     o_wrap
);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeFwd  = 2'b01,
    ModeRev  = 2'b10,
    ModePing = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  localparam logic [SEL_W-1:0] LastMax = SEL_W'(NUM_PAT - 1);

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               wrap_q, wrap_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic [SEL_W-1:0]   last_eff;
  logic               step;
  mode_e              mode;
  logic [SEG_W-1:0]   pat_arr [NUM_PAT];
  logic [SEG_W-1:0]   sel_pat;

  assign mode = mode_e'(i_mode);

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_unpack
    assign pat_arr[k] = i_patterns[k*SEG_W +: SEG_W];
  end

  assign last_eff = (i_last > LastMax) ? LastMax : i_last;

  // Dwell counter; '>=' makes a lowered i_dwell step on the next enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_en) begin
      if (mode == ModeHold) begin
        cnt_d = '0;
      end else if (cnt_q >= i_dwell) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    idx_d  = idx_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (i_load) begin
      idx_d = (i_load_idx > last_eff) ? last_eff : i_load_idx;
      dir_d = DirUp;
    end else if (step) begin
      unique case (mode)
        ModeFwd: begin
          if (idx_q >= last_eff) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ModeRev: begin
          if (idx_q == '0) begin
            idx_d  = last_eff;
            wrap_d = 1'b1;
          end else if (idx_q > last_eff) begin
            idx_d = last_eff;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        ModePing: begin
          if (dir_q == DirUp) begin
            if (idx_q >= last_eff) begin
              dir_d = DirDown;
              if (last_eff == '0) begin
                idx_d  = '0;
                wrap_d = 1'b1;
              end else begin
                idx_d = last_eff - 1'b1;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            if (idx_q == '0) begin
              dir_d  = DirUp;
              idx_d  = (last_eff == '0) ? '0 : SEL_W'(1);
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Select from the next index so o_seg always lines up with o_idx.
  assign sel_pat = pat_arr[idx_d];

  always_comb begin
`ifdef SEQ_BLANK_EN
    seg_d = i_blank ? '0 : sel_pat;
`else
    seg_d = sel_pat;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= DirUp;
      wrap_q <= 1'b0;
      seg_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
    end
  end

  assign o_seg  = seg_q;
  assign o_idx  = idx_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_seg_pattern_sequencer.sv
// Self-checking bench for seg_pattern_sequencer: directed scenarios plus randomized stimulus
// against a behavioural model. Blanking scenarios compile in with `define SEQ_BLANK_EN.
module tb_seg_pattern_sequencer;
  localparam int SEG_W   = 7;
  localparam int NUM_PAT = 16;
  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_PAT*SEG_W-1:0] patterns;
  logic                     en;
  logic [1:0]               mode;
  logic [DWELL_W-1:0]       dwell;
  logic [SEL_W-1:0]         last;
  logic                     load;
  logic [SEL_W-1:0]         load_idx;
  logic                     blank;
  logic [SEG_W-1:0]         seg;
  logic [SEL_W-1:0]         idx;
  logic                     wrap;

  int checks = 0;
  int errors = 0;

  // Model state: plain integers, direction as +1/-1.
  int m_idx, m_cnt, m_dir, m_wrap, m_seg;

  int fwd_exp [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int pp_exp  [6]  = '{1, 2, 1, 0, 1, 2};
  int pp_wrap [6]  = '{0, 0, 0, 0, 1, 0};
  int rev_exp [5]  = '{3, 2, 1, 0, 3};
  int rev_wrap[5]  = '{0, 0, 0, 0, 1};

  seg_pattern_sequencer #(
    .SEG_W  (SEG_W),
    .NUM_PAT(NUM_PAT),
    .SEL_W  (SEL_W),
    .DWELL_W(DWELL_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_patterns(patterns),
    .i_en      (en),
    .i_mode    (mode),
    .i_dwell   (dwell),
    .i_last    (last),
    .i_load    (load),
    .i_load_idx(load_idx),
`ifdef SEQ_BLANK_EN
    .i_blank   (blank),
`endif
    .o_seg     (seg),
    .o_idx     (idx),
    .o_wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pat_of(input int k);
    return int'(patterns[k*SEG_W +: SEG_W]);
  endfunction

  function automatic void model_tick();
    int lim;
    lim    = (int'(last) > NUM_PAT - 1) ? NUM_PAT - 1 : int'(last);
    m_wrap = 0;
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_dir = 1; m_seg = 0;
      return;
    end
    if (load) begin
      m_idx = (int'(load_idx) < lim) ? int'(load_idx) : lim;
      m_cnt = 0;
      m_dir = 1;
    end else if (en && mode == 2'd0) begin
      m_cnt = 0;
    end else if (en) begin
      if (m_cnt >= int'(dwell)) begin
        m_cnt = 0;
        case (mode)
          2'd1: if (m_idx >= lim) begin m_idx = 0; m_wrap = 1; end else m_idx++;
          2'd2: begin
            if (m_idx == 0) begin m_idx = lim; m_wrap = 1; end
            else if (m_idx > lim) m_idx = lim;
            else m_idx--;
          end
          default: begin
            if (m_dir > 0 && m_idx >= lim) begin
              m_dir  = -1;
              m_idx  = (lim == 0) ? 0 : lim - 1;
              m_wrap = (lim == 0) ? 1 : 0;
            end else if (m_dir < 0 && m_idx == 0) begin
              m_dir  = 1;
              m_idx  = (lim == 0) ? 0 : 1;
              m_wrap = 1;
            end else begin
              m_idx += m_dir;
            end
          end
        endcase
      end else begin
        m_cnt++;
      end
    end
    m_seg = blank ? 0 : pat_of(m_idx);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    check_eq("model_idx", 32'(idx), 32'(m_idx));
    check_eq("model_seg", 32'(seg), 32'(m_seg));
    check_eq("model_wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    for (int k = 0; k < NUM_PAT; k++) patterns[k*SEG_W +: SEG_W] = 7'(8'h10 + k);
    rst = 1'b1; en = 1'b1; mode = 2'd1; dwell = 8'd2; last = 4'd3;
    load = 1'b0; load_idx = '0; blank = 1'b0;
    m_idx = 0; m_cnt = 0; m_dir = 1; m_wrap = 0; m_seg = 0;

    // Reset, then forward run with dwell 2, last 3.
    tick();
    tick();
    check_eq("rst_idx", 32'(idx), 32'd0);
    check_eq("rst_seg", 32'(seg), 32'd0);
    check_eq("rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check_eq("rst_first_seg", 32'(seg), 32'h10);
      check_eq("fwd_idx", 32'(idx), 32'(fwd_exp[i]));
      check_eq("fwd_wrap", 32'(wrap), (i == 11) ? 32'd1 : 32'd0);
    end

    // Ping-pong, dwell 0, last 2.
    mode = 2'd3; dwell = 8'd0; last = 4'd2; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("pp_idx", 32'(idx), 32'(pp_exp[i]));
      check_eq("pp_wrap", 32'(wrap), 32'(pp_wrap[i]));
    end

    // Reverse from 5 with last lowered to 3.
    last = 4'd15; load = 1'b1; load_idx = 4'd5; en = 1'b0;
    tick();
    check_eq("rev_load", 32'(idx), 32'd5);
    load = 1'b0; mode = 2'd2; last = 4'd3; dwell = 8'd0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rev_idx", 32'(idx), 32'(rev_exp[i]));
      check_eq("rev_wrap", 32'(wrap), 32'(rev_wrap[i]));
    end

    // Load beats a coincident step and clamps to last.
    mode = 2'd1; dwell = 8'd0; en = 1'b1; last = 4'd6; load = 1'b1; load_idx = 4'd9;
    tick();
    check_eq("load_idx", 32'(idx), 32'd6);
    check_eq("load_wrap", 32'(wrap), 32'd0);
    load = 1'b0; en = 1'b0;
    tick();
    check_eq("load_frozen_idx", 32'(idx), 32'd6);
    check_eq("load_seg", 32'(seg), 32'h16);

`ifdef SEQ_BLANK_EN
    // Blank three cycles while the index keeps advancing.
    last = 4'd15; load = 1'b1; load_idx = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("blank_seg", 32'(seg), 32'd0);
      check_eq("blank_idx", 32'(idx), 32'(i + 1));
    end
    blank = 1'b0;
    tick();
    check_eq("unblank_idx", 32'(idx), 32'd4);
    check_eq("unblank_seg", 32'(seg), 32'h14);
`endif

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 24) == 0);
      load_idx = SEL_W'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) dwell = DWELL_W'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        dwell = (dwell > 0) ? dwell - 1'b1 : dwell;
      end
      if ($urandom_range(0, 29) == 0) last = SEL_W'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        int s;
        s = int'($urandom_range(0, NUM_PAT - 1));
        patterns[s*SEG_W +: SEG_W] = SEG_W'($urandom());
      end
`ifdef SEQ_BLANK_EN
      blank = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_pattern_sequencer.md
Name: seg_pattern_sequencer

Overview:
Parametrised, clocked successor to the combinational 16-way segment-pattern mux. Holds up to NUM_PAT seven-segment patterns on a flattened bus. Steps through them autonomously with a programmable dwell time, in one of four modes: hold, forward, reverse, ping-pong. Sits between the effect pattern generators and the display driver; provides a registered segment output, the current index and a wrap pulse.

Parameters:
SEG_W, 7, width of one segment pattern
NUM_PAT, 16, number of pattern slots (2..256)
SEL_W, 4, index width; must equal clog2(NUM_PAT)
DWELL_W, 8, width of dwell counter and i_dwell

Ports:
i_clk  input  1  clock
i_rst  input  1  reset
i_patterns  input  NUM_PAT*SEG_W  pattern k at [k*SEG_W +: SEG_W]
i_en  input  1  advance enable; low freezes dwell counter and index
i_mode  input  2  00 hold, 01 forward, 10 reverse, 11 ping-pong
i_dwell  input  DWELL_W  cycles per pattern minus one
i_last  input  SEL_W  highest index in sequence; values >= NUM_PAT clamp to NUM_PAT-1
i_load  input  1  load index strobe
i_load_idx  input  SEL_W  index to load (clamped to effective last)
o_seg  output  SEG_W  registered segment pattern for o_idx
o_idx  output  SEL_W  current pattern index
o_wrap  output  1  one-cycle pulse on sequence wrap/turnaround

Behaviour:
- Single clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_idx=0, o_seg=0, o_wrap=0, dwell count=0, direction=up.
- o_seg <= pattern[idx_next] every cycle (including when frozen), so o_seg always matches o_idx. Pattern-data changes show up one cycle later.
- Dwell: with i_en=1 and mode!=hold, count increments each cycle.
  - When count==i_dwell, a step occurs and count returns to 0.
  - i_dwell=0 steps every enabled cycle.
  - If i_dwell is lowered below the current count, the step occurs on the next enabled cycle.
- Hold mode: count held at 0, index held.
- Effective last L = min(i_last, NUM_PAT-1).
- Forward step: idx==L or idx>L -> 0 with o_wrap=1; otherwise idx+1.
- Reverse step: idx==0 -> L with o_wrap=1; idx>L -> L with no wrap; otherwise idx-1.
- Ping-pong (direction flag up/down):
  - Up at idx>=L: direction=down, idx=L-1 (L if L==0).
  - Down at idx==0: direction=up, idx=1 (0 if L==0), o_wrap=1.
  - Otherwise idx±1.
  - L==0: idx stays 0, o_wrap pulses on every step.
- o_wrap is registered, high exactly one cycle, in the same cycle the new o_idx appears.
- i_load has priority over a step and over i_en:
  - idx=min(i_load_idx, L), count=0, direction=up, no o_wrap.
  - o_seg shows the loaded pattern the next cycle.
- Mode change mid-dwell: count is not cleared; the new mode applies at the next step. Direction flag persists into ping-pong.
- Reset asserted mid-sequence overrides load and step in that cycle.

Optional Feature:
SEQ_BLANK_EN:
- When defined, adds input i_blank (1 bit).
- While i_blank=1, o_seg loads 0 instead of the selected pattern. Index, dwell and o_wrap continue unaffected.
- The cycle after i_blank falls, o_seg shows pattern[o_idx] again.
- When undefined, the port is absent and o_seg always carries the selected pattern.

Test Plan:
- Reset: assert i_rst 2 cycles with patterns k=7'h10+k -> o_idx=0, o_seg=0, o_wrap=0. First cycle after release -> o_seg=7'h10.
- Forward, i_dwell=2, i_last=3, i_en=1 -> o_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. o_wrap high only in the cycle o_idx returns to 0.
- Ping-pong, i_dwell=0, i_last=2 -> o_idx 0,1,2,1,0,1,2. o_wrap high in the cycle o_idx=1 following 0 (turnaround), not at 2.
- Reverse from idx=5 with i_last lowered to 3 -> next step o_idx=3, no wrap. Then 2,1,0,3 with o_wrap on 0->3.
- Load priority: i_load=1, i_load_idx=9, i_last=6, coincident with a step -> o_idx=6, count=0, o_wrap=0. With i_en=0 the next cycle, o_idx stays 6.
- SEQ_BLANK_EN build: i_blank high 3 cycles during forward run -> o_seg=0 for 3 cycles while o_idx keeps advancing; pattern returns the cycle after i_blank falls.
